// File: rtl/brent_kung_divider_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : brent_kung_divider_controller_pkg
// Purpose  : Shared definitions for the restoring divider controller:
//            FSM state encoding, default operand width and the width of the
//            iteration counter.
// Revision : 1.0 - initial release
// ============================================================================
package brent_kung_divider_controller_pkg;

    // Default operand/result width of the divider and its trial subtractor.
    localparam int c_DEFAULT_WIDTH = 8;

    // Counter width needed to count WIDTH iterations (0 .. WIDTH-1).
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int c_DEFAULT_CNT_W = cnt_width(c_DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/brent_kung_adder.sv
`default_nettype none
// ============================================================================
// Module   : brent_kung_adder
// Purpose  : Parallel-prefix adder using the Brent-Kung up-sweep/down-sweep
//            carry network. sum = a + b + cin, cout = carry out of the MSB.
// Ports    : a, b  [WIDTH-1:0] addends
//            cin               carry in
//            sum   [WIDTH-1:0] result modulo 2^WIDTH
//            cout              carry out
// Revision : 1.0 - initial release
// ============================================================================
module brent_kung_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int c_LOG = $clog2(WIDTH);

    logic [WIDTH-1:0] w_p0;  // bitwise propagate, also the half-sum
    logic [WIDTH-1:0] w_g;   // group generate, becomes prefix carry G[i:-1]
    logic [WIDTH-1:0] w_p;   // group propagate (only needed during up-sweep)

    assign w_p0 = a ^ b;

    // The network is evaluated in place: at every level the node being
    // combined never reads another node updated on that same level, so a
    // single pair of vectors is enough. cin is folded into bit 0 so every
    // prefix already includes it.
    always_comb begin
        w_g    = a & b;
        w_p    = w_p0;
        w_g[0] = (a[0] & b[0]) | (w_p0[0] & cin);

        // Up-sweep: nodes at i = k*2^(l+1) - 1 absorb the block below.
        for (int l = 0; l < c_LOG; l++) begin
            for (int i = (2 << l) - 1; i < WIDTH; i += (2 << l)) begin
                w_g[i] = w_g[i] | (w_p[i] & w_g[i - (1 << l)]);
                w_p[i] = w_p[i] & w_p[i - (1 << l)];
            end
        end

        // Down-sweep: fill in the remaining prefixes from full ones below.
        for (int l = c_LOG - 2; l >= 0; l--) begin
            for (int i = 3 * (1 << l) - 1; i < WIDTH; i += (2 << l)) begin
                w_g[i] = w_g[i] | (w_p[i] & w_g[i - (1 << l)]);
            end
        end
    end

    assign sum  = w_p0 ^ {w_g[WIDTH-2:0], cin};
    assign cout = w_g[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/brent_kung_divider_controller.sv
`default_nettype none
// ============================================================================
// Module   : brent_kung_divider_controller
// Purpose  : Sequential restoring divider driven from a switch/button panel.
//            Operands are captured from the shared switch bus; a rising edge
//            on start launches a WIDTH-cycle divide that produces one
//            quotient bit per clock using a Brent-Kung adder as the trial
//            subtractor (R + ~B + 1).
// Ports    : clk, rst_n        clock, synchronous active-low reset
//            in      [W-1:0]   switch bus operand value
//            store_A, store_B  load dividend / divisor from in (IDLE/DONE)
//            start             button level, launches on rising edge
//            quotient[W-1:0]   registered quotient of the last completion
//            remainder[W-1:0]  registered remainder of the last completion
//            busy              high while dividing
//            done              high once a result is available
//            div_zero          high with done when the divisor was zero
// Revision : 1.0 - initial release
// ============================================================================
module brent_kung_divider_controller
    import brent_kung_divider_controller_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             store_A,
    input  logic             store_B,
    input  logic             start,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int                c_CNT_W = cnt_width(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_num_a;
    logic [WIDTH-1:0]   r_num_b;
    logic [WIDTH-1:0]   r_acc_r;     // working partial remainder
    logic [WIDTH-1:0]   r_acc_q;     // working dividend/quotient shift register
    logic [c_CNT_W-1:0] r_count;
    logic               r_start_d;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_rem;
    logic               r_busy;
    logic               r_done;
    logic               r_div_zero;

    logic               w_start_edge;
    logic               w_msb;
    logic [WIDTH-1:0]   w_r_sh;
    logic [WIDTH-1:0]   w_diff;
    logic               w_cout;
    logic               w_ok;
    logic [WIDTH-1:0]   w_r_next;
    logic [WIDTH-1:0]   w_q_next;

    assign w_start_edge = start & ~r_start_d;

    // One step of {R,Q} << 1. The bit shifted out of R is the hidden ninth
    // bit of the shifted remainder; when it is set the subtraction always
    // fits even though the adder's carry out does not show it.
    assign w_msb  = r_acc_r[WIDTH-1];
    assign w_r_sh = {r_acc_r[WIDTH-2:0], r_acc_q[WIDTH-1]};

    brent_kung_adder #(
        .WIDTH (WIDTH)
    ) u_trial_sub (
        .a    (w_r_sh),
        .b    (~r_num_b),
        .cin  (1'b1),
        .sum  (w_diff),
        .cout (w_cout)
    );

    assign w_ok     = w_cout | w_msb;
    assign w_r_next = w_ok ? w_diff : w_r_sh;
    assign w_q_next = {r_acc_q[WIDTH-2:0], w_ok};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_num_a    <= '0;
            r_num_b    <= '0;
            r_acc_r    <= '0;
            r_acc_q    <= '0;
            r_count    <= '0;
            r_start_d  <= 1'b0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            // Tracks the button in every state so a press held across the
            // end of a divide cannot relaunch it.
            r_start_d <= start;

            case (r_state)
                IDLE, DONE: begin
                    // Launch decisions below read the pre-edge operands, so a
                    // simultaneous store only affects the next run.
                    if (store_A) r_num_a <= in;
                    if (store_B) r_num_b <= in;

                    if (w_start_edge) begin
                        if (r_num_b == '0) begin
                            r_quot     <= '1;
                            r_rem      <= r_num_a;
                            r_div_zero <= 1'b1;
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= DONE;
                        end else begin
                            r_acc_r    <= '0;
                            r_acc_q    <= r_num_a;
                            r_count    <= '0;
                            r_div_zero <= 1'b0;
                            r_done     <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= CALC;
                        end
                    end
                end

                CALC: begin
                    r_acc_r <= w_r_next;
                    r_acc_q <= w_q_next;
                    r_count <= r_count + 1'b1;
                    if (r_count == c_LAST) begin
                        r_quot  <= w_q_next;
                        r_rem   <= w_r_next;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign busy      = r_busy;
    assign done      = r_done;
    assign div_zero  = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_brent_kung_divider_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_brent_kung_divider_controller
// Purpose  : Directed self-checking bench for the restoring divider
//            controller, with hand-computed expected results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_brent_kung_divider_controller;

    localparam int c_W = 8;

    logic           clk;
    logic           rst_n;
    logic [c_W-1:0] in_bus;
    logic           store_A;
    logic           store_B;
    logic           start;
    logic [c_W-1:0] quotient;
    logic [c_W-1:0] remainder;
    logic           busy;
    logic           done;
    logic           div_zero;

    int checks = 0;
    int errors = 0;

    brent_kung_divider_controller #(
        .WIDTH (c_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_bus),
        .store_A   (store_A),
        .store_B   (store_B),
        .start     (start),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic store_ops(input int a, input int b);
        in_bus  = c_W'(a);
        store_A = 1'b1;
        step();
        store_A = 1'b0;
        in_bus  = c_W'(b);
        store_B = 1'b1;
        step();
        store_B = 1'b0;
    endtask

    // Press start for one edge, then expect busy until done on edge k+8.
    task automatic launch_and_wait(input string tag, input int eq, input int er);
        int n;
        bit busy_ok;
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, " busy@accept"}, busy, 1);
        check({tag, " done@accept"}, done, 0);
        n = 0;
        busy_ok = 1'b1;
        while (!done && n < 20) begin
            if (!busy) busy_ok = 1'b0;
            step();
            n++;
        end
        check({tag, " latency"}, n, 8);
        check({tag, " busy held"}, busy_ok, 1);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " div_zero"}, div_zero, 0);
        check({tag, " busy@done"}, busy, 0);
    endtask

    initial begin
        int  n;
        int  first_done;
        bit  relaunch;

        rst_n   = 1'b0;
        in_bus  = '0;
        store_A = 1'b0;
        store_B = 1'b0;
        start   = 1'b0;
        step();
        step();
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset div_zero", div_zero, 0);
        rst_n = 1'b1;
        step();

        store_ops(200, 7);
        launch_and_wait("200/7", 28, 4);

        store_ops(255, 1);
        launch_and_wait("255/1", 255, 0);

        // Divide by zero resolves on the accepting edge without busy.
        store_ops(37, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("37/0 done", done, 1);
        check("37/0 div_zero", div_zero, 1);
        check("37/0 quotient", quotient, 255);
        check("37/0 remainder", remainder, 37);
        check("37/0 busy", busy, 0);
        step();

        store_ops(5, 9);
        launch_and_wait("5/9", 0, 5);

        store_ops(255, 128);
        launch_and_wait("255/128", 1, 127);

        // Held start: one division only; stores during CALC ignored.
        store_ops(100, 7);
        start = 1'b1;
        step();
        first_done = -1;
        relaunch   = 1'b0;
        for (int i = 1; i < 30; i++) begin
            store_A = (i == 2);
            store_B = (i == 3);
            in_bus  = (i == 2) ? 8'd99 : 8'd3;
            step();
            if (done && first_done < 0) first_done = i;
            if (first_done >= 0 && busy) relaunch = 1'b1;
        end
        store_A = 1'b0;
        store_B = 1'b0;
        check("held first done", first_done, 8);
        check("held no relaunch", relaunch, 0);
        check("held done", done, 1);
        check("held quotient", quotient, 14);
        check("held remainder", remainder, 2);
        start = 1'b0;
        step();
        // Operands must still be 100/7 since the CALC stores were ignored.
        launch_and_wait("reuse 100/7", 14, 2);

        // Extra start edge during CALC must not disturb the run.
        store_ops(200, 7);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        n = 2;
        while (!done && n < 20) begin
            step();
            n++;
        end
        check("extra edge latency", n, 8);
        check("extra edge quotient", quotient, 28);
        check("extra edge remainder", remainder, 4);

        // A store in DONE keeps done and the outputs.
        in_bus  = 8'd5;
        store_A = 1'b1;
        step();
        store_A = 1'b0;
        check("store in DONE done", done, 1);
        check("store in DONE quotient", quotient, 28);

        store_ops(99, 3);
        launch_and_wait("99/3", 33, 0);

        // Reset in the middle of CALC discards the partial run.
        store_ops(100, 10);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midreset quotient", quotient, 0);
        check("midreset remainder", remainder, 0);
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset div_zero", div_zero, 0);
        step();
        check("post-reset idle busy", busy, 0);
        check("post-reset idle done", done, 0);
        // Cleared operands show up as a zero-divisor result with remainder 0.
        start = 1'b1;
        step();
        start = 1'b0;
        check("cleared ops div_zero", div_zero, 1);
        check("cleared ops quotient", quotient, 255);
        check("cleared ops remainder", remainder, 0);
        step();

        store_ops(100, 10);
        launch_and_wait("100/10", 10, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
